// File: rtl/sdram_pkg.sv
// Shared definitions for the two-master SDRAM bridge arbiter: FSM encodings,
// port indices and the idle byte-select value.
package sdram_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_t;

  localparam logic ARB_PORT_I = 1'b0;  // instruction fetch unit
  localparam logic ARB_PORT_D = 1'b1;  // data / load-store unit

  localparam logic [3:0] BYTESEL_NONE = 4'b0000;

  function automatic logic is_request(input logic [3:0] bytesel);
    return bytesel != BYTESEL_NONE;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational 2-way request picker. Round-robin on the last-grant pointer by
// default; with SDRAM_ARB_FIXED_PRIO_EN defined, port 0 always wins a tie.
module sdram_arb_pick
  import sdram_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic grant_valid
);

  assign grant_valid = req0 | req1;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = req0 ? ARB_PORT_I : ARB_PORT_D;
  end
`else
  always_comb begin
    if (req0 && req1) begin
      grant = ~last;
    end else if (req0) begin
      grant = ARB_PORT_I;
    end else begin
      grant = ARB_PORT_D;
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the 32-bit host port of the SDRAM bridge between the fetch unit
// (port 0) and the load-store unit (port 1). Build option: SDRAM_ARB_FIXED_PRIO_EN.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [31:0]           m1_wdata,
  output logic [31:0]           m0_rdata,
  output logic [31:0]           m1_rdata,
  input  logic                  m0_wr_en,
  input  logic                  m1_wr_en,
  input  logic [3:0]            m0_bytesel,
  input  logic [3:0]            m1_bytesel,
  output logic                  m0_compl,
  output logic                  m1_compl,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [31:0]           b_wdata,
  input  logic [31:0]           b_rdata,
  output logic                  b_wr_en,
  output logic [3:0]            b_bytesel,
  input  logic                  b_compl
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant;
  logic       pick_grant, pick_valid;

  logic [ADDR_WIDTH-1:0] sel_addr, b_addr_d;
  logic [31:0]           sel_wdata, b_wdata_d;
  logic                  sel_wr_en, b_wr_en_d;
  logic [3:0]            sel_bytesel, b_bytesel_d;
  logic [31:0]           m0_rdata_d, m1_rdata_d;
  logic                  m0_compl_d, m1_compl_d;

  sdram_arb_pick u_pick (
    .req0        (is_request(m0_bytesel)),
    .req1        (is_request(m1_bytesel)),
    .last        (last_grant),
    .grant       (pick_grant),
    .grant_valid (pick_valid)
  );

  assign sel_addr    = (pick_grant == ARB_PORT_D) ? m1_addr    : m0_addr;
  assign sel_wdata   = (pick_grant == ARB_PORT_D) ? m1_wdata   : m0_wdata;
  assign sel_wr_en   = (pick_grant == ARB_PORT_D) ? m1_wr_en   : m0_wr_en;
  assign sel_bytesel = (pick_grant == ARB_PORT_D) ? m1_bytesel : m0_bytesel;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign last_grant = ARB_PORT_D;
`else
  logic last_grant_d;

  // Reset to port 1 so the fetch unit wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ARB_PORT_D;
    end else begin
      last_grant <= last_grant_d;
    end
  end
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    b_addr_d    = b_addr;
    b_wdata_d   = b_wdata;
    b_wr_en_d   = b_wr_en;
    b_bytesel_d = b_bytesel;
    m0_rdata_d  = m0_rdata;
    m1_rdata_d  = m1_rdata;
    m0_compl_d  = 1'b0;
    m1_compl_d  = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_grant;
          b_addr_d    = sel_addr;
          b_wdata_d   = sel_wdata;
          b_wr_en_d   = sel_wr_en;
          b_bytesel_d = sel_bytesel;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (b_compl) begin
          if (!b_wr_en) begin
            if (grant_q == ARB_PORT_D) m1_rdata_d = b_rdata;
            else                       m0_rdata_d = b_rdata;
          end
          // Completion is registered here so it is visible during DONE.
          m0_compl_d  = (grant_q == ARB_PORT_I);
          m1_compl_d  = (grant_q == ARB_PORT_D);
          b_bytesel_d = BYTESEL_NONE;
          state_d     = ARB_DONE;
        end
      end
      ARB_DONE: begin
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        last_grant_d = grant_q;
`endif
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= ARB_PORT_I;
      b_addr    <= '0;
      b_wdata   <= '0;
      b_wr_en   <= 1'b0;
      b_bytesel <= BYTESEL_NONE;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_compl  <= 1'b0;
      m1_compl  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      b_addr    <= b_addr_d;
      b_wdata   <= b_wdata_d;
      b_wr_en   <= b_wr_en_d;
      b_bytesel <= b_bytesel_d;
      m0_rdata  <= m0_rdata_d;
      m1_rdata  <= m1_rdata_d;
      m0_compl  <= m0_compl_d;
      m1_compl  <= m1_compl_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level arbitration model.
module tb_sdram_arbiter;

  localparam int AW = 32;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic          clk, rst_n;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_wr_en, m1_wr_en;
  logic [3:0]    m0_bytesel, m1_bytesel;
  logic          m0_compl, m1_compl;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata, b_rdata;
  logic          b_wr_en;
  logic [3:0]    b_bytesel;
  logic          b_compl;

  sdram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_wr_en(m0_wr_en), .m1_wr_en(m1_wr_en),
    .m0_bytesel(m0_bytesel), .m1_bytesel(m1_bytesel),
    .m0_compl(m0_compl), .m1_compl(m1_compl),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata),
    .b_wr_en(b_wr_en), .b_bytesel(b_bytesel), .b_compl(b_compl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: who was served last and what each master last read.
  logic        last_m;
  logic [31:0] exp_rdata [2];

  // Observations of the transfer currently on the bridge.
  int            obs_wait;
  logic [AW-1:0] obs_addr;
  logic [31:0]   obs_wdata;
  logic          obs_wr;
  logic [3:0]    obs_bs, obs_bs_done;
  logic          obs_hold_ok;
  logic          obs_c0, obs_c1, obs_c0b, obs_c1b;

  logic both_compl_seen = 1'b0;
  always @(negedge clk) if (m0_compl && m1_compl) both_compl_seen = 1'b1;

  function automatic int model_winner(input bit act0, input bit act1, input logic last);
    if (act0 && act1) return FIXED_PRIO ? 0 : (last ? 0 : 1);
    return act0 ? 0 : 1;
  endfunction

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic wr, input logic [3:0] bs);
    if (p == 0) begin
      m0_addr = a; m0_wdata = d; m0_wr_en = wr; m0_bytesel = bs;
    end else begin
      m1_addr = a; m1_wdata = d; m1_wr_en = wr; m1_bytesel = bs;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) m0_bytesel = 4'h0;
    else        m1_bytesel = 4'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    b_compl = 1'b0;
    b_rdata = '0;
    set_req(0, '0, '0, 1'b0, 4'h0);
    set_req(1, '0, '0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // Wait (bounded) for the bridge request to appear and capture it.
  task automatic xfer_start();
    obs_wait = 0;
    while (b_bytesel == 4'h0 && obs_wait < 50) begin
      @(negedge clk);
      obs_wait++;
    end
    obs_addr  = b_addr;
    obs_wdata = b_wdata;
    obs_wr    = b_wr_en;
    obs_bs    = b_bytesel;
  endtask

  // Bridge model: hold for lat cycles, pulse b_compl, watch the completion.
  task automatic xfer_finish(input int lat, input logic [31:0] rd);
    obs_hold_ok = 1'b1;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (b_bytesel !== obs_bs || b_addr !== obs_addr || b_wdata !== obs_wdata ||
          b_wr_en !== obs_wr || m0_compl || m1_compl) obs_hold_ok = 1'b0;
    end
    b_compl = 1'b1;
    b_rdata = rd;
    @(negedge clk);
    b_compl = 1'b0;
    b_rdata = $urandom;
    obs_c0 = m0_compl;
    obs_c1 = m1_compl;
    obs_bs_done = b_bytesel;
    @(negedge clk);
    obs_c0b = m0_compl;
    obs_c1b = m1_compl;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({b_wr_en, b_bytesel} !== 5'b0) $display("FAIL reset_wr_bs: got %b want 00000", {b_wr_en, b_bytesel});
    else n_pass++;
    n_total++;
    if (b_addr !== '0 || b_wdata !== '0) $display("FAIL reset_addr_wdata: got %h/%h want 0/0", b_addr, b_wdata);
    else n_pass++;
    n_total++;
    if (m0_rdata !== '0 || m1_rdata !== '0) $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    else n_pass++;
    n_total++;
    if ({m0_compl, m1_compl} !== 2'b00) $display("FAIL reset_compl: got %b want 00", {m0_compl, m1_compl});
    else n_pass++;
  endtask

  task automatic test_single_read();
    set_req(0, 32'h100, $urandom, 1'b0, 4'hF);
    xfer_start();
    n_total++;
    if (obs_wait !== 1) $display("FAIL rd_latency: got %0d cycles want 1", obs_wait);
    else n_pass++;
    n_total++;
    if ({obs_addr, obs_wr, obs_bs} !== {32'h100, 1'b0, 4'hF})
      $display("FAIL rd_bridge: got addr %h wr %b bs %h want 100 0 f", obs_addr, obs_wr, obs_bs);
    else n_pass++;
    xfer_finish(3, 32'hDEADBEEF);
    exp_rdata[0] = 32'hDEADBEEF;
    last_m = 1'b0;
    drop_req(0);
    n_total++;
    if ({obs_c0, obs_c1, obs_c0b, obs_c1b} !== 4'b1000)
      $display("FAIL rd_compl: got %b want 1000", {obs_c0, obs_c1, obs_c0b, obs_c1b});
    else n_pass++;
    n_total++;
    if (m0_rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", m0_rdata);
    else n_pass++;
    n_total++;
    if ({obs_hold_ok, obs_bs_done} !== 5'b10000)
      $display("FAIL rd_hold_release: got hold %b bs %h want 1 0", obs_hold_ok, obs_bs_done);
    else n_pass++;
  endtask

  task automatic test_single_write();
    set_req(1, 32'h204, 32'h12345678, 1'b1, 4'hC);
    xfer_start();
    n_total++;
    if ({obs_addr, obs_wdata, obs_wr, obs_bs} !== {32'h204, 32'h12345678, 1'b1, 4'hC})
      $display("FAIL wr_bridge: got %h %h %b %h want 204 12345678 1 c", obs_addr, obs_wdata, obs_wr, obs_bs);
    else n_pass++;
    xfer_finish(2, 32'hA5A5A5A5);
    last_m = 1'b1;
    drop_req(1);
    n_total++;
    if ({obs_c0, obs_c1, obs_c0b, obs_c1b} !== 4'b0100)
      $display("FAIL wr_compl: got %b want 0100", {obs_c0, obs_c1, obs_c0b, obs_c1b});
    else n_pass++;
    n_total++;
    if (m1_rdata !== exp_rdata[1] || m0_rdata !== exp_rdata[0])
      $display("FAIL wr_rdata_kept: got %h/%h want %h/%h", m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a0, a1;
    logic [31:0] rd;
    int got;
    apply_reset();
    a0 = 32'h1000;
    a1 = 32'h2000;
    set_req(0, a0, '0, 1'b0, 4'hF);
    set_req(1, a1, '0, 1'b0, 4'h3);
    for (int k = 0; k < 4; k++) begin
      xfer_start();
      rd = $urandom;
      xfer_finish(int'($urandom_range(0, 3)), rd);
      got = obs_c1 ? 1 : 0;
      n_total++;
      if (got !== (FIXED_PRIO ? 0 : k % 2) || (obs_c0 && obs_c1))
        $display("FAIL rr_order_%0d: got port %0d (c=%b%b) want %0d", k, got, obs_c0, obs_c1,
                 FIXED_PRIO ? 0 : k % 2);
      else n_pass++;
      n_total++;
      if (obs_addr !== (got == 0 ? a0 : a1))
        $display("FAIL rr_addr_%0d: got %h want %h", k, obs_addr, got == 0 ? a0 : a1);
      else n_pass++;
      exp_rdata[got] = rd;
      last_m = logic'(got);
      if (got == 0) begin a0 += 4; set_req(0, a0, '0, 1'b0, 4'hF); end
      else          begin a1 += 4; set_req(1, a1, '0, 1'b0, 4'h3); end
    end
    drop_req(0);
    drop_req(1);
    n_total++;
    if (m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1])
      $display("FAIL rr_rdata: got %h/%h want %h/%h", m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_req(1, 32'h3000, $urandom, 1'b1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      xfer_start();
      n_total++;
      if (obs_wait !== 1) $display("FAIL b2b_gap_%0d: got %0d cycles want 1", k, obs_wait);
      else n_pass++;
      xfer_finish(int'($urandom_range(0, 2)), $urandom);
      n_total++;
      if (obs_bs_done !== 4'h0 || obs_c1 !== 1'b1)
        $display("FAIL b2b_release_%0d: got bs %h c1 %b want 0 1", k, obs_bs_done, obs_c1);
      else n_pass++;
      last_m = 1'b1;
      set_req(1, 32'h3000 + 32'(4 * (k + 1)), $urandom, 1'b1, 4'hF);
    end
    drop_req(1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    set_req(1, 32'h280, '0, 1'b0, 4'hF);
    xfer_start();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (b_bytesel !== 4'h0) $display("FAIL rstmid_bytesel: got %h want 0", b_bytesel);
    else n_pass++;
    drop_req(1);
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if ({m0_compl, m1_compl} !== 2'b00) $display("FAIL rstmid_compl: got %b want 00", {m0_compl, m1_compl});
      else n_pass++;
    end
    rst_n = 1'b1;
    last_m = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    @(negedge clk);
    n_total++;
    if ({m0_compl, m1_compl, b_bytesel, m1_rdata} !== 38'h0)
      $display("FAIL rstmid_after: got c %b bs %h rd %h want 0", {m0_compl, m1_compl}, b_bytesel, m1_rdata);
    else n_pass++;
    rd = $urandom;
    set_req(1, 32'h300, '0, 1'b0, 4'h6);
    xfer_start();
    xfer_finish(1, rd);
    drop_req(1);
    exp_rdata[1] = rd;
    last_m = 1'b1;
    n_total++;
    if ({obs_addr, obs_bs, obs_c0, obs_c1} !== {32'h300, 4'h6, 2'b01} || m1_rdata !== rd)
      $display("FAIL rstmid_fresh: got %h %h c %b%b rd %h want 300 6 c 01 rd %h",
               obs_addr, obs_bs, obs_c0, obs_c1, m1_rdata, rd);
    else n_pass++;
  endtask

  task automatic test_withdraw_spurious();
    int activity;
    set_req(1, 32'h500, 32'hCAFEF00D, 1'b1, 4'h1);
    xfer_start();
    set_req(0, 32'h400, '0, 1'b0, 4'hF);
    @(negedge clk);
    drop_req(0);
    xfer_finish(2, $urandom);
    drop_req(1);
    last_m = 1'b1;
    n_total++;
    if ({obs_c0, obs_c1} !== 2'b01) $display("FAIL wd_compl: got %b want 01", {obs_c0, obs_c1});
    else n_pass++;
    activity = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_bytesel != 4'h0 || m0_compl || m1_compl) activity++;
    end
    n_total++;
    if (activity !== 0) $display("FAIL wd_no_issue: got %0d active cycles want 0", activity);
    else n_pass++;
    b_compl = 1'b1;
    @(negedge clk);
    b_compl = 1'b0;
    activity = 0;
    repeat (3) begin
      if (b_bytesel != 4'h0 || m0_compl || m1_compl) activity++;
      @(negedge clk);
    end
    n_total++;
    if (activity !== 0) $display("FAIL spurious_compl: got %0d active cycles want 0", activity);
    else n_pass++;
  endtask

  task automatic test_random();
    bit            act [2];
    logic [AW-1:0] r_addr [2];
    logic [31:0]   r_wdata [2];
    logic          r_wr [2];
    logic [3:0]    r_bs [2];
    logic [31:0]   rd;
    int            w;
    act[0] = 1'b0;
    act[1] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 1) == 1) act[p] = 1'b1;
      end
      if (!act[0] && !act[1]) act[$urandom_range(0, 1)] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (act[p] && (p == 0 ? m0_bytesel : m1_bytesel) == 4'h0) begin
          r_addr[p]  = $urandom;
          r_wdata[p] = $urandom;
          r_wr[p]    = 1'($urandom_range(0, 1));
          r_bs[p]    = 4'($urandom_range(1, 15));
          set_req(p, r_addr[p], r_wdata[p], r_wr[p], r_bs[p]);
        end
      end
      w = model_winner(act[0], act[1], last_m);
      xfer_start();
      n_total++;
      if (obs_wait !== 1) $display("FAIL rnd_latency_%0d: got %0d want 1", it, obs_wait);
      else n_pass++;
      n_total++;
      if ({obs_addr, obs_wdata, obs_wr, obs_bs} !== {r_addr[w], r_wdata[w], r_wr[w], r_bs[w]})
        $display("FAIL rnd_bridge_%0d: got %h %h %b %h want %h %h %b %h (port %0d)", it,
                 obs_addr, obs_wdata, obs_wr, obs_bs, r_addr[w], r_wdata[w], r_wr[w], r_bs[w], w);
      else n_pass++;
      rd = $urandom;
      xfer_finish(int'($urandom_range(0, 4)), rd);
      if (!r_wr[w]) exp_rdata[w] = rd;
      last_m = logic'(w);
      n_total++;
      if ({obs_c0, obs_c1} !== (w == 0 ? 2'b10 : 2'b01))
        $display("FAIL rnd_compl_%0d: got %b want port %0d", it, {obs_c0, obs_c1}, w);
      else n_pass++;
      n_total++;
      if ({obs_c0b, obs_c1b, obs_bs_done, obs_hold_ok} !== 7'b0000001)
        $display("FAIL rnd_pulse_%0d: got c %b%b bs %h hold %b want 00 0 1", it,
                 obs_c0b, obs_c1b, obs_bs_done, obs_hold_ok);
      else n_pass++;
      n_total++;
      if (m0_rdata !== exp_rdata[0] || m1_rdata !== exp_rdata[1])
        $display("FAIL rnd_rdata_%0d: got %h/%h want %h/%h", it, m0_rdata, m1_rdata,
                 exp_rdata[0], exp_rdata[1]);
      else n_pass++;
      act[w] = 1'b0;
      drop_req(w);
    end
    drop_req(0);
    drop_req(1);
  endtask

  task automatic test_invariant();
    n_total++;
    if (both_compl_seen !== 1'b0) $display("FAIL compl_exclusive: got both high want never");
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_withdraw_spurious();
    test_random();
    test_invariant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
